seq_div_unit: RTL and testbench

//  Multi-cycle restoring divider for the multi-cycle CPU datapath. Adders compute A+B;

---
 rtl/seq_div_unit.sv | 134 +++++++++++++
 tb/tb_seq_div_unit.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/seq_div_unit.sv
// Multi-cycle restoring divider: one trial subtraction per clock over WIDTH steps.
// Optional signed support is enabled by defining SEQ_DIV_SIGNED_EN.
module seq_div_unit #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             signed_op,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int unsigned CW = $clog2(WIDTH);

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_q;
  logic [WIDTH-1:0] r_r;
  logic [WIDTH-1:0] r_d;
  logic [CW-1:0]    r_count;

  logic [WIDTH:0]   w_rs;
  logic [WIDTH:0]   w_t;
  logic [WIDTH-1:0] w_q_nxt;
  logic [WIDTH-1:0] w_r_nxt;
  logic [WIDTH-1:0] w_q_fix;
  logic [WIDTH-1:0] w_r_fix;
  logic [WIDTH-1:0] w_dd_mag;
  logic [WIDTH-1:0] w_dv_mag;
  logic             w_last;

  // One restoring step: shift in next dividend bit, trial-subtract the divisor
  always_comb begin
    w_rs    = {r_r, r_q[WIDTH-1]};
    w_t     = w_rs - {1'b0, r_d};
    w_q_nxt = {r_q[WIDTH-2:0], ~w_t[WIDTH]};
    w_r_nxt = w_t[WIDTH] ? w_rs[WIDTH-1:0] : w_t[WIDTH-1:0];
    w_last  = (r_count == CW'(WIDTH - 1));
  end

`ifdef SEQ_DIV_SIGNED_EN
  logic r_neg_q;
  logic r_neg_r;
  logic w_neg_q;
  logic w_neg_r;

  // Operands become magnitudes at launch; results get their signs back at the end
  always_comb begin
    w_dd_mag = (signed_op && dividend[WIDTH-1]) ? WIDTH'(-dividend) : dividend;
    w_dv_mag = (signed_op && divisor[WIDTH-1])  ? WIDTH'(-divisor)  : divisor;
    w_neg_q  = signed_op & (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
    w_neg_r  = signed_op & dividend[WIDTH-1];
    w_q_fix  = r_neg_q ? WIDTH'(-w_q_nxt) : w_q_nxt;
    w_r_fix  = r_neg_r ? WIDTH'(-w_r_nxt) : w_r_nxt;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_neg_q <= 1'b0;
      r_neg_r <= 1'b0;
    end else if ((r_state != S_CALC) && start) begin
      r_neg_q <= w_neg_q;
      r_neg_r <= w_neg_r;
    end
  end
`else
  logic w_unused_signed;

  always_comb begin
    w_dd_mag        = dividend;
    w_dv_mag        = divisor;
    w_q_fix         = w_q_nxt;
    w_r_fix         = w_r_nxt;
    w_unused_signed = signed_op;
  end
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_q         <= '0;
      r_r         <= '0;
      r_d         <= '0;
      r_count     <= '0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE, S_DONE: begin
          r_state <= S_IDLE;
          if (start) begin
            r_q         <= w_dd_mag;
            r_r         <= '0;
            r_d         <= w_dv_mag;
            r_count     <= '0;
            div_by_zero <= 1'b0;
            if (divisor == '0) begin
              // Zero divisor skips the iterations entirely
              quotient    <= '1;
              remainder   <= dividend;
              div_by_zero <= 1'b1;
              r_state     <= S_DONE;
            end else begin
              r_state <= S_CALC;
            end
          end
        end
        S_CALC: begin
          r_q     <= w_q_nxt;
          r_r     <= w_r_nxt;
          r_count <= r_count + 1'b1;
          if (w_last) begin
            quotient  <= w_q_fix;
            remainder <= w_r_fix;
            r_state   <= S_DONE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign busy = (r_state == S_CALC);
  assign done = (r_state == S_DONE);

endmodule

// File: tb/tb_seq_div_unit.sv
// Directed self-checking bench for seq_div_unit (WIDTH=32); signed cases need SEQ_DIV_SIGNED_EN.
module tb_seq_div_unit;

  localparam int unsigned WIDTH = 32;

  logic             clk;
  logic             rst;
  logic             start;
  logic             signed_op;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic             div_by_zero;

  int n_cmp;
  int n_err;

  seq_div_unit #(.WIDTH(WIDTH)) u_dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .signed_op   (signed_op),
    .dividend    (dividend),
    .divisor     (divisor),
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Waits for done; cyc counts negedges after the launching edge, bsy counts busy cycles
  task automatic wait_done(output int cyc, output int bsy);
    cyc = 1;
    bsy = 0;
    while (!done && cyc < 200) begin
      if (busy) bsy++;
      @(negedge clk);
      cyc++;
    end
  endtask

  task automatic run(input string tag, input logic [WIDTH-1:0] dd, input logic [WIDTH-1:0] dv,
                     input logic sop, input logic [WIDTH-1:0] eq, input logic [WIDTH-1:0] er,
                     input logic ez, input int elat);
    int cyc;
    int bsy;
    @(negedge clk);
    dividend  = dd;
    divisor   = dv;
    signed_op = sop;
    start     = 1'b1;
    @(negedge clk);
    start    = 1'b0;
    dividend = 32'hDEAD_BEEF;
    divisor  = 32'h0000_0003;
    wait_done(cyc, bsy);
    check({tag, " latency"}, 64'(cyc), 64'(elat));
    check({tag, " quotient"}, 64'(quotient), 64'(eq));
    check({tag, " remainder"}, 64'(remainder), 64'(er));
    check({tag, " div_by_zero"}, 64'(div_by_zero), 64'(ez));
    @(negedge clk);
    check({tag, " done pulse width"}, 64'(done), 64'd0);
  endtask

  initial begin
    int cyc;
    int bsy;
    n_cmp     = 0;
    n_err     = 0;
    rst       = 1'b1;
    start     = 1'b0;
    signed_op = 1'b0;
    dividend  = '0;
    divisor   = '0;
    #12;
    check("reset busy", 64'(busy), 64'd0);
    check("reset done", 64'(done), 64'd0);
    check("reset quotient", 64'(quotient), 64'd0);
    check("reset remainder", 64'(remainder), 64'd0);
    check("reset div_by_zero", 64'(div_by_zero), 64'd0);
    @(negedge clk);
    rst = 1'b0;

    // Basic unsigned with busy-length check
    @(negedge clk);
    dividend = 32'd100;
    divisor  = 32'd7;
    start    = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(cyc, bsy);
    check("100/7 latency", 64'(cyc), 64'd33);
    check("100/7 busy cycles", 64'(bsy), 64'd32);
    check("100/7 quotient", 64'(quotient), 64'd14);
    check("100/7 remainder", 64'(remainder), 64'd2);
    @(negedge clk);
    check("100/7 done pulse width", 64'(done), 64'd0);

    run("max/1", 32'hFFFF_FFFF, 32'd1, 1'b0, 32'hFFFF_FFFF, 32'd0, 1'b0, 33);
    run("5/9", 32'd5, 32'd9, 1'b0, 32'd0, 32'd5, 1'b0, 33);
    run("1234/0", 32'd1234, 32'd0, 1'b0, 32'hFFFF_FFFF, 32'd1234, 1'b1, 1);
    run("zero flag clear", 32'd1000, 32'd10, 1'b0, 32'd100, 32'd0, 1'b0, 33);
    run("max/max-1", 32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b0, 32'd1, 32'd1, 1'b0, 33);

`ifdef SEQ_DIV_SIGNED_EN
    run("s -7/2", 32'hFFFF_FFF9, 32'd2, 1'b1, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0, 33);
    run("s 7/-2", 32'd7, 32'hFFFF_FFFE, 1'b1, 32'hFFFF_FFFD, 32'd1, 1'b0, 33);
    run("s min/-1", 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 32'h8000_0000, 32'd0, 1'b0, 33);
    run("s -7/-2", 32'hFFFF_FFF9, 32'hFFFF_FFFE, 1'b1, 32'd3, 32'hFFFF_FFFF, 1'b0, 33);
`else
    run("u signed_op ignored", 32'hFFFF_FFF9, 32'd2, 1'b1, 32'h7FFF_FFFC, 32'd1, 1'b0, 33);
`endif

    // Reset in the middle of CALC aborts with all outputs cleared at once
    @(negedge clk);
    signed_op = 1'b0;
    dividend  = 32'd100;
    divisor   = 32'd7;
    start     = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (10) @(negedge clk);
    rst = 1'b1;
    #1;
    check("abort busy", 64'(busy), 64'd0);
    check("abort done", 64'(done), 64'd0);
    check("abort quotient", 64'(quotient), 64'd0);
    check("abort remainder", 64'(remainder), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (done) check("abort no done", 64'(done), 64'd0);
    end
    run("9/3 after abort", 32'd9, 32'd3, 1'b0, 32'd3, 32'd0, 1'b0, 33);

    // start held through CALC is ignored; relaunch from DONE is back-to-back
    @(negedge clk);
    dividend = 32'd20;
    divisor  = 32'd4;
    start    = 1'b1;
    @(negedge clk);
    dividend = 32'd50;
    divisor  = 32'd6;
    wait_done(cyc, bsy);
    check("held start latency", 64'(cyc), 64'd33);
    check("held start quotient", 64'(quotient), 64'd5);
    check("held start remainder", 64'(remainder), 64'd0);
    @(negedge clk);
    dividend = 32'd1;
    divisor  = 32'd1;
    cyc = 1;
    while (!done && cyc < 200) begin
      @(negedge clk);
      cyc++;
    end
    start = 1'b0;
    check("back-to-back spacing", 64'(cyc), 64'd33);
    check("back-to-back quotient", 64'(quotient), 64'd8);
    check("back-to-back remainder", 64'(remainder), 64'd2);
    @(negedge clk);
    check("back-to-back idle", 64'(done | busy), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
